// File: rtl/trace_capture_buffer_pkg.sv
// Shared types for the commit-trace capture buffer: FSM states and the stored entry layout.
package trace_pkg;

  localparam int TRACE_XLEN  = 32;
  localparam int TRACE_TS_W  = 16;
  localparam int TRACE_INSTR = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Field order matches the packing used for the RAM word: {pc, instr, result, ts}.
  typedef struct packed {
    logic [TRACE_XLEN-1:0]  pc;
    logic [TRACE_INSTR-1:0] instr;
    logic [TRACE_XLEN-1:0]  result;
    logic [TRACE_TS_W-1:0]  ts;
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_capture_buffer_if.sv
// Retire tap and readout stream of the trace buffer.
// Handshake: an entry transfers on a clock edge where rd_valid && rd_ready; while rd_valid is
// high and rd_ready low, rd_* are held stable. cap_valid is a one-cycle qualifier with no back-pressure.
interface trace_capture_buffer_if #(
  parameter int XLEN = 32,
  parameter int TS_W = 16
);
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_instr;
  logic [XLEN-1:0] cap_result;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic [XLEN-1:0] rd_result;
  logic [TS_W-1:0] rd_ts;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_result, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_result, rd_ts
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_result, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_result, rd_ts
  );
endinterface

// File: rtl/trace_capture_buffer_ram.sv
// Trace storage: register array with one write port and an asynchronous read port.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = trace_pkg::TRACE_ENTRY_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/trace_capture_buffer.sv
// Commit-trace capture: circular record of retired instructions, frozen a fixed number of
// entries after a PC-match or forced trigger, then streamed out oldest-first.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int TS_W      = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  trace_capture_buffer_if.slave bus,
  input  logic                  arm,
  input  logic                  trig_en,
  input  logic [XLEN-1:0]       trig_pc,
  input  logic                  force_trig,
  output logic [1:0]            state,
  output logic [CW-1:0]         count,
  output logic                  triggered
);
  localparam int EW = 2 * XLEN + 32 + TS_W;

  trace_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_q, post_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          trig_q, trig_d;
  logic          force_q, force_d;
  logic [TS_W-1:0] ts_q;

  logic          cap_we, trig_hit, rd_valid, rd_fire;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] wdata, rdata;

  // An arm in the same cycle as a retire restarts the window without storing that entry.
  assign cap_we   = bus.cap_valid && !arm && (state_q == ST_ARMED || state_q == ST_POST);
  assign trig_hit = cap_we && (state_q == ST_ARMED) &&
                    ((trig_en && bus.cap_pc == trig_pc) || force_q || force_trig);
  assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
  assign rd_fire  = rd_valid && bus.rd_ready;
  // Oldest entry sits count positions behind the write pointer; a full buffer wraps to wr_ptr.
  assign rd_ptr   = wr_ptr_q - count_q[AW-1:0];
  assign wdata    = {bus.cap_pc, bus.cap_instr, bus.cap_result, ts_q};

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (cap_we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      post_q   <= '0;
      wr_ptr_q <= '0;
      trig_q   <= 1'b0;
      force_q  <= 1'b0;
      ts_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      post_q   <= post_d;
      wr_ptr_q <= wr_ptr_d;
      trig_q   <= trig_d;
      force_q  <= force_d;
      ts_q     <= ts_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    post_d   = post_q;
    wr_ptr_d = wr_ptr_q;
    trig_d   = trig_q;
    force_d  = force_q || force_trig;
    if (arm) begin
      state_d  = ST_ARMED;
      count_d  = '0;
      wr_ptr_d = '0;
      trig_d   = 1'b0;
      force_d  = 1'b0;
    end else begin
      if (cap_we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
      end
      unique case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (trig_hit) begin
            trig_d  = 1'b1;
            force_d = 1'b0;
            post_d  = CW'(POST_TRIG);
            state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (cap_we) begin
            post_d = post_q - 1'b1;
            if (post_q == CW'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (rd_fire) begin
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign state         = state_q;
  assign count         = count_q;
  assign triggered     = trig_q;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_pc     = rd_valid ? rdata[EW-1 -: XLEN]             : '0;
  assign bus.rd_instr  = rd_valid ? rdata[XLEN+TS_W +: 32]          : '0;
  assign bus.rd_result = rd_valid ? rdata[TS_W +: XLEN]             : '0;
  assign bus.rd_ts     = rd_valid ? rdata[TS_W-1:0]                 : '0;
endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer (DEPTH=8, POST_TRIG=2) with a pc scoreboard.
module tb_trace_capture_buffer;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  localparam int POST_TRIG = 2;
  localparam int TS_W = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            arm = 1'b0;
  logic            trig_en = 1'b0;
  logic [XLEN-1:0] trig_pc = '0;
  logic            force_trig = 1'b0;
  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic            triggered;

  trace_capture_buffer_if #(.XLEN(XLEN), .TS_W(TS_W)) bus ();

  trace_capture_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .arm        (arm),
    .trig_en    (trig_en),
    .trig_pc    (trig_pc),
    .force_trig (force_trig),
    .state      (state),
    .count      (count),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic frc);
    bus.cap_valid  = 1'b1;
    bus.cap_pc     = pc;
    bus.cap_instr  = pc ^ 32'h13;
    bus.cap_result = pc + 32'h100;
    force_trig     = frc;
    step();
    bus.cap_valid  = 1'b0;
    force_trig     = 1'b0;
  endtask

  task automatic retire_range(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] pc = lo; pc <= hi; pc += 4) retire(pc, 1'b0);
  endtask

  task automatic load_exp(input logic [31:0] lo, input logic [31:0] hi);
    exp_q.delete();
    for (logic [31:0] pc = lo; pc <= hi; pc += 4) exp_q.push_back(pc);
  endtask

  // Drains the stream at full rate; entries were captured back-to-back so ts steps by 1.
  task automatic read_all();
    int budget = 40;
    logic first = 1'b1;
    logic [TS_W-1:0] prev_ts = '0;
    logic [31:0] e;
    bus.rd_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      check("rd_valid_stream", bus.rd_valid, 1);
      if (bus.rd_valid) begin
        e = exp_q.pop_front();
        check("rd_pc", bus.rd_pc, e);
        check("rd_instr", bus.rd_instr, e ^ 32'h13);
        check("rd_result", bus.rd_result, e + 32'h100);
        if (!first) check("rd_ts_step", bus.rd_ts, prev_ts + 1'b1);
        prev_ts = bus.rd_ts;
        first = 1'b0;
      end
      step();
      budget--;
    end
    bus.rd_ready = 1'b0;
    check("read_left", exp_q.size(), 0);
    check("idle_after_read", state, 0);
    check("rd_valid_after_read", bus.rd_valid, 0);
    check("rd_pc_after_read", bus.rd_pc, 0);
  endtask

  initial begin
    bus.cap_valid = 1'b0;
    bus.cap_pc = '0;
    bus.cap_instr = '0;
    bus.cap_result = '0;
    bus.rd_ready = 1'b0;

    // Reset
    step();
    step();
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_triggered", triggered, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_pc", bus.rd_pc, 0);
    rst = 1'b1;
    step();

    // Wrap-around window with backpressure
    trig_en = 1'b1;
    trig_pc = 32'h20;
    do_arm();
    check("armed_state", state, 1);
    check("armed_count", count, 0);
    retire_range(32'h00, 32'h1C);
    check("pre_trig_count", count, 8);
    check("pre_trig_flag", triggered, 0);
    retire(32'h20, 1'b0);
    check("post_state", state, 2);
    check("post_triggered", triggered, 1);
    retire_range(32'h24, 32'h2C);
    check("wrap_state", state, 3);
    check("wrap_count", count, 8);
    for (int i = 0; i < 3; i++) begin
      check("bp_rd_valid", bus.rd_valid, 1);
      check("bp_rd_pc", bus.rd_pc, 32'h0C);
      step();
    end
    check("bp_count", count, 8);
    load_exp(32'h0C, 32'h28);
    read_all();

    // Early trigger
    trig_pc = 32'h04;
    do_arm();
    retire_range(32'h00, 32'h2C);
    check("early_state", state, 3);
    check("early_count", count, 4);
    load_exp(32'h00, 32'h0C);
    read_all();

    // Force trigger with PC match disabled
    trig_en = 1'b0;
    do_arm();
    retire_range(32'h30, 32'h3C);
    check("force_pre_flag", triggered, 0);
    check("force_pre_state", state, 1);
    retire(32'h40, 1'b1);
    check("force_triggered", triggered, 1);
    check("force_state", state, 2);
    retire_range(32'h44, 32'h4C);
    check("force_done", state, 3);
    check("force_count", count, 7);
    load_exp(32'h30, 32'h48);
    read_all();

    // Abort during readout; the retire in the arm cycle must not be stored
    trig_en = 1'b1;
    trig_pc = 32'h08;
    do_arm();
    retire_range(32'h00, 32'h2C);
    check("abort_pre_count", count, 5);
    check("abort_pre_valid", bus.rd_valid, 1);
    bus.cap_valid = 1'b1;
    bus.cap_pc = 32'h99;
    do_arm();
    bus.cap_valid = 1'b0;
    check("abort_state", state, 1);
    check("abort_count", count, 0);
    check("abort_rd_valid", bus.rd_valid, 0);
    check("abort_triggered", triggered, 0);
    step();
    check("abort_not_stored", count, 0);

    // Reset mid-capture discards the trace
    retire_range(32'h100, 32'h104);
    check("mid_count", count, 2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_state", state, 0);
    check("midrst_count", count, 0);
    retire(32'h108, 1'b0);
    check("idle_no_capture", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Parametrised on-chip commit-trace capture for the single-cycle RISC-V core. It replaces ad-hoc `$display` monitoring with a synthesisable circular buffer. The buffer records every retired instruction (PC, instruction word, writeback result, cycle timestamp) while armed. It freezes a configurable number of entries after a PC-match or forced trigger, then streams the captured window out oldest-first over a valid/ready port. It sits beside `cpu_top` and taps its retire signals, so the trace is observable in simulation and on hardware alike.

## Interface
- `XLEN`, 32, width of PC and result fields
- `DEPTH`, 16, number of trace entries; power of two, ≥ 4
- `POST_TRIG`, 4, entries captured after the trigger entry; 0 ≤ POST_TRIG < DEPTH
- `TS_W`, 16, timestamp counter width
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-low
- `cap_valid` in 1: one instruction retired this cycle
- `cap_pc` in XLEN: PC of the retired instruction
- `cap_instr` in 32: retired instruction word
- `cap_result` in XLEN: writeback/ALU result
- `arm` in 1: pulse; clear buffer and start capture
- `trig_en` in 1: enable PC-match trigger
- `trig_pc` in XLEN: trigger PC
- `force_trig` in 1: immediate trigger on the next captured entry
- `rd_valid` out 1: readout entry available
- `rd_ready` in 1: consumer accepts the entry
- `rd_pc`, `rd_instr`, `rd_result`, `rd_ts` out XLEN/32/XLEN/TS_W: entry fields
- `state` out 2: 0 IDLE, 1 ARMED, 2 POST, 3 DONE
- `count` out $clog2(DEPTH)+1: valid entries held
- `triggered` out 1: trigger has fired since the last arm

## Operation
- Free-running `ts` counter increments every cycle, wraps mod 2^TS_W, and is cleared by reset only. Stored `rd_ts` is the `ts` value in the capture cycle.
- **IDLE:** nothing is captured. `arm` clears `count`, `wr_ptr`, and `triggered`, then moves to ARMED.
- **ARMED:** each `cap_valid` writes mem[wr_ptr]; `wr_ptr` wraps mod DEPTH. `count` saturates at DEPTH, so the oldest entry is overwritten.
- **Trigger:** fires on a captured entry when `(trig_en && cap_pc==trig_pc) || force_latched`. `force_latched` is set by `force_trig` and held until consumed. A `force_trig` in the same cycle as a capture applies to that entry.
  - The trigger entry is stored and `triggered` is set.
  - If POST_TRIG=0, the state goes to DONE; otherwise it goes to POST with `post_cnt=POST_TRIG`.
- **POST:** each capture stores an entry and decrements `post_cnt`. The capture that brings it to 0 moves the state to DONE. Triggers in POST are ignored.
- **DONE:** captures are ignored and the read pointer is `wr_ptr - count` (mod DEPTH).
  - `rd_valid = (count != 0)`.
  - Each `rd_valid && rd_ready` advances the read pointer and decrements `count`.
  - When the last entry is accepted, the state goes to IDLE.
- `arm` in any state aborts: it clears `count`, `triggered`, `force_latched`, and `rd_valid`, then moves to ARMED. An `arm` coinciding with a `cap_valid` does not capture that entry.

## Timing
- Capture latency is 1 cycle: an entry written at edge N is counted at N+1.
- The trigger decision is combinational on `cap_*`. The state change is visible the cycle after the trigger capture.
- Readout is combinational from the registered read pointer. `rd_*` fields are stable while `rd_valid && !rd_ready`, with one entry per cycle at full throughput.
- Reset values: `state`=IDLE, `count`=0, `triggered`=0, `rd_valid`=0, `rd_*`=0, `ts`=0.
- Mem contents are not reset. `rd_*` fields are forced to 0 while `rd_valid`=0.
- Reset asserted mid-capture or mid-readout returns the block to IDLE on the next edge and discards the trace.

## Structure
- The shared package `trace_pkg` holds:
  - the `trace_state_e` enum (IDLE/ARMED/POST/DONE)
  - the `trace_entry_t` packed struct {pc, instr, result, ts}, with widths from package localparams matching XLEN=32/TS_W=16 defaults
- One sub-module, `trace_ram`: a DEPTH×entry register array with a single write port and an asynchronous read port.
- The control FSM, pointers, and counters live in the top module.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles → state=0, count=0, triggered=0, rd_valid=0, rd_pc=0.
- **Wrap-around window:** DEPTH=8, POST_TRIG=2, `trig_pc`=0x20, arm, then retire PCs 0x00..0x2C in steps of 4 → DONE after 0x28, count=8. Readout yields 0x0C,0x10,…,0x28 in order, and 0x2C is absent. After the last read the state is IDLE.
- **Early trigger:** `trig_pc`=0x04, same stimulus → count=4. Readout is 0x00,0x04,0x08,0x0C, with `rd_ts` strictly increasing.
- **Backpressure:** in DONE, hold `rd_ready`=0 for 3 cycles → `rd_valid`=1 and `rd_pc` unchanged. Then `rd_ready`=1 → one entry per cycle.
- **Force trigger:** `trig_en`=0, `force_trig` pulsed on the same cycle as retire PC 0x40, POST_TRIG=2 → the trigger entry is 0x40, the last entry is 0x48, and triggered=1.
- **Abort:** `arm` pulsed during readout with count=5 → next cycle state=ARMED, count=0, rd_valid=0. A `cap_valid` in the arm cycle is not stored.
